// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronises and edge-latches N interrupt lines, feeds the
// masked pending vector to an external priority encoder and runs the CPU req/ack handshake.
module irq_pending_ctrl #(
    parameter int N           = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    irq_mask,
    output logic [N-1:0]    pend_vec,
    input  logic [ID_W-1:0] enc_idx,
    input  logic            enc_valid,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ack,
    output logic [N-1:0]    irq_lost,
    input  logic            lost_clr
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            req_next;
    logic [ID_W-1:0] id_next;

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_out;
    logic [N-1:0] prev;
    logic [N-1:0] edge_det;
    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic [N-1:0] clr_vec;
    logic [N-1:0] lost_set;
    logic [N-1:0] lost_next;
    logic         ack_fire;

    // Per-line synchroniser chain; the last stage is the only one used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_out & ~prev;
    assign ack_fire = (state == WAIT_ACK) && irq_ack;

    always_comb begin
        clr_vec = '0;
        if (ack_fire) begin
            clr_vec[irq_id] = 1'b1;
        end
    end

    // A new edge beats a same-cycle clear, and is then not counted as lost.
    assign pending_next = (pending & ~clr_vec) | edge_det;
    assign lost_set     = edge_det & pending & ~clr_vec;
    assign lost_next    = (lost_clr ? '0 : irq_lost) | lost_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            pending  <= '0;
            irq_lost <= '0;
        end else begin
            prev     <= sync_out;
            pending  <= pending_next;
            irq_lost <= lost_next;
        end
    end

    assign pend_vec = pending & irq_mask;

    always_comb begin
        state_next = state;
        req_next   = irq_req;
        id_next    = irq_id;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    id_next    = enc_idx;
                    req_next   = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (irq_ack) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            state   <= state_next;
            irq_req <= req_next;
            irq_id  <= id_next;
        end
    end

endmodule
